// File: rtl/bomb_scheduler_pkg.sv
// Shared tile-grid constants and bomb slot state encoding for the bomb scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bomb_scheduler_pkg;

   localparam int TILE_SHIFT = 4;    // 16x16 pixel tiles
   localparam int TX_W       = 6;    // tile column width
   localparam int TY_W       = 5;    // tile row width

   localparam logic [TX_W-1:0] GRID_W = 6'd40;
   localparam logic [TY_W-1:0] GRID_H = 5'd30;
   localparam logic [9:0]      PIX_W  = 10'd640;
   localparam logic [9:0]      PIX_H  = 10'd480;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FUSE  = 2'd1,
      BLAST = 2'd2
   } slot_state_e;

   function automatic logic tile_in_grid(input logic [TX_W-1:0] tx, input logic [TY_W-1:0] ty);
      return (tx < GRID_W) && (ty < GRID_H);
   endfunction

endpackage

// File: rtl/bomb_scheduler_if.sv
// Bundle of game-side and renderer-side signals around the bomb scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; every request is answered by a one-cycle ack or nack pulse.
// Ports: master = game/renderer side (drives tick, place_*, px/py);
//        slave  = scheduler (drives place_ack/nack, pix_*, boom_*, active_count).
interface bomb_scheduler_if;
   import bomb_scheduler_pkg::*;

   logic            tick;
   logic            place_req;
   logic [TX_W-1:0] place_tx;
   logic [TY_W-1:0] place_ty;
   logic            place_ack;
   logic            place_nack;
   logic [9:0]      px;
   logic [9:0]      py;
   logic            pix_bomb;
   logic            pix_blast;
   logic            boom_valid;
   logic [TX_W-1:0] boom_tx;
   logic [TY_W-1:0] boom_ty;
   logic [3:0]      active_count;

   modport master (
      output tick, place_req, place_tx, place_ty, px, py,
      input  place_ack, place_nack, pix_bomb, pix_blast,
             boom_valid, boom_tx, boom_ty, active_count
   );

   modport slave (
      input  tick, place_req, place_tx, place_ty, px, py,
      output place_ack, place_nack, pix_bomb, pix_blast,
             boom_valid, boom_tx, boom_ty, active_count
   );

endinterface

// File: rtl/bomb_scheduler_slot.sv
// One bomb slot: IDLE -> FUSE -> BLAST -> IDLE driven by game ticks, plus a pending-event flag.
// Latency: state/timer/pending update on the clock edge after alloc_i, tick_i or clear_pending_i.
// Backpressure: none; the owner must only allocate an IDLE, non-pending slot.
// Ports: clk, rst (sync, active-high); alloc_i with tx_i/ty_i loads a new bomb; tick_i advances
//        the timer; clear_pending_i drops the event flag; busy_o/state_o/tx_o/ty_o/pending_o.
module bomb_scheduler_slot
   import bomb_scheduler_pkg::*;
#(
   parameter int FUSE_TICKS  = 3,
   parameter int BLAST_TICKS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc_i,
   input  logic [TX_W-1:0] tx_i,
   input  logic [TY_W-1:0] ty_i,
   input  logic            tick_i,
   input  logic            clear_pending_i,
   output logic            busy_o,
   output slot_state_e     state_o,
   output logic [TX_W-1:0] tx_o,
   output logic [TY_W-1:0] ty_o,
   output logic            pending_o
);

   localparam logic [3:0] FUSE_LOAD  = 4'(FUSE_TICKS);
   localparam logic [3:0] BLAST_LOAD = 4'(BLAST_TICKS);

   slot_state_e     state_q, state_d;
   logic [3:0]      timer_q, timer_d;
   logic [TX_W-1:0] tx_q, tx_d;
   logic [TY_W-1:0] ty_q, ty_d;
   logic            pending_q, pending_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         tx_q      <= '0;
         ty_q      <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      pending_d = pending_q;

      // Clear can never coincide with a fresh set: a slot only re-arms after its event drained.
      if (clear_pending_i) pending_d = 1'b0;

      // A freshly allocated bomb ignores a simultaneous tick so it gets the full fuse.
      if (alloc_i) begin
         state_d = FUSE;
         timer_d = FUSE_LOAD;
         tx_d    = tx_i;
         ty_d    = ty_i;
      end else if (tick_i) begin
         case (state_q)
            FUSE: begin
               if (timer_q > 4'd1) begin
                  timer_d = timer_q - 4'd1;
               end else begin
                  state_d   = BLAST;
                  timer_d   = BLAST_LOAD;
                  pending_d = 1'b1;
               end
            end
            BLAST: begin
               if (timer_q > 4'd1) begin
                  timer_d = timer_q - 4'd1;
               end else begin
                  state_d = IDLE;
                  timer_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Coordinates stay valid in IDLE so a pending event can still report them.
   assign busy_o    = (state_q != IDLE);
   assign state_o   = state_q;
   assign tx_o      = tx_q;
   assign ty_o      = ty_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb slot pool: placement with duplicate/range checks, tick-driven timers, detonation events, tile queries.
// Latency: ack/nack, boom, pix_* and active_count are all registered, one cycle after the causing input/state.
// Backpressure: none; place requests are always answered next cycle, booms serialise lowest slot first.
// Ports: clk, rst (sync, active-high); bus (slave modport): tick, place_req/tx/ty -> place_ack/nack;
//        px/py -> pix_bomb/pix_blast; boom_valid/tx/ty; active_count.
module bomb_scheduler
   import bomb_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS   = 4,
   parameter int FUSE_TICKS  = 3,
   parameter int BLAST_TICKS = 1
) (
   input  logic            clk,
   input  logic            rst,
   bomb_scheduler_if.slave bus
);

   logic [NUM_SLOTS-1:0] busy_vec, pend_vec, alloc_vec, clr_vec, free_vec;
   slot_state_e          s_state [NUM_SLOTS];
   logic [TX_W-1:0]      s_tx    [NUM_SLOTS];
   logic [TY_W-1:0]      s_ty    [NUM_SLOTS];

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      bomb_scheduler_slot #(
         .FUSE_TICKS  (FUSE_TICKS),
         .BLAST_TICKS (BLAST_TICKS)
      ) u_slot (
         .clk             (clk),
         .rst             (rst),
         .alloc_i         (alloc_vec[g]),
         .tx_i            (bus.place_tx),
         .ty_i            (bus.place_ty),
         .tick_i          (bus.tick),
         .clear_pending_i (clr_vec[g]),
         .busy_o          (busy_vec[g]),
         .state_o         (s_state[g]),
         .tx_o            (s_tx[g]),
         .ty_o            (s_ty[g]),
         .pending_o       (pend_vec[g])
      );
   end

   // Allocator and duplicate check, both on pre-tick state: a slot freed by this
   // cycle's tick is still BLAST here and only becomes allocatable next cycle.
   logic dup_hit, free_found, accept;

   always_comb begin
      dup_hit    = 1'b0;
      free_found = 1'b0;
      free_vec   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (busy_vec[i] && (s_tx[i] == bus.place_tx) && (s_ty[i] == bus.place_ty))
            dup_hit = 1'b1;
         if (!free_found && !busy_vec[i] && !pend_vec[i]) begin
            free_vec[i] = 1'b1;
            free_found  = 1'b1;
         end
      end
      accept    = bus.place_req && tile_in_grid(bus.place_tx, bus.place_ty) && !dup_hit && free_found;
      alloc_vec = accept ? free_vec : '0;
   end

   // Event serialiser: lowest pending slot wins, one event per cycle.
   logic            ev_found;
   logic [TX_W-1:0] ev_tx;
   logic [TY_W-1:0] ev_ty;

   always_comb begin
      ev_found = 1'b0;
      ev_tx    = '0;
      ev_ty    = '0;
      clr_vec  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!ev_found && pend_vec[i]) begin
            ev_found   = 1'b1;
            ev_tx      = s_tx[i];
            ev_ty      = s_ty[i];
            clr_vec[i] = 1'b1;
         end
      end
   end

   // Pixel tile match; blast overrides bomb when both hit the same tile.
   logic            pix_in, hit_bomb, hit_blast;
   logic [TX_W-1:0] qx;
   logic [TY_W-1:0] qy;
   logic [3:0]      count_d;

   assign qx     = bus.px[TILE_SHIFT +: TX_W];
   assign qy     = bus.py[TILE_SHIFT +: TY_W];
   assign pix_in = (bus.px < PIX_W) && (bus.py < PIX_H);

   always_comb begin
      hit_bomb  = 1'b0;
      hit_blast = 1'b0;
      count_d   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if ((s_tx[i] == qx) && (s_ty[i] == qy)) begin
            if (s_state[i] == FUSE)  hit_bomb  = 1'b1;
            if (s_state[i] == BLAST) hit_blast = 1'b1;
         end
         count_d = count_d + {3'b000, busy_vec[i]};
      end
   end

   logic            ack_q, nack_q, boom_valid_q, pix_bomb_q, pix_blast_q;
   logic [TX_W-1:0] boom_tx_q;
   logic [TY_W-1:0] boom_ty_q;
   logic [3:0]      count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q        <= 1'b0;
         nack_q       <= 1'b0;
         boom_valid_q <= 1'b0;
         boom_tx_q    <= '0;
         boom_ty_q    <= '0;
         pix_bomb_q   <= 1'b0;
         pix_blast_q  <= 1'b0;
         count_q      <= '0;
      end else begin
         ack_q        <= accept;
         nack_q       <= bus.place_req && !accept;
         boom_valid_q <= ev_found;
         if (ev_found) begin
            boom_tx_q <= ev_tx;
            boom_ty_q <= ev_ty;
         end
         pix_blast_q  <= pix_in && hit_blast;
         pix_bomb_q   <= pix_in && hit_bomb && !hit_blast;
         count_q      <= count_d;
      end
   end

   assign bus.place_ack    = ack_q;
   assign bus.place_nack   = nack_q;
   assign bus.boom_valid   = boom_valid_q;
   assign bus.boom_tx      = boom_tx_q;
   assign bus.boom_ty      = boom_ty_q;
   assign bus.pix_bomb     = pix_bomb_q;
   assign bus.pix_blast    = pix_blast_q;
   assign bus.active_count = count_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: directed scenarios then random traffic, checked every cycle against a lifetime model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bomb_scheduler;

   localparam int NS = 4;
   localparam int FT = 3;
   localparam int BT = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bomb_scheduler_if bus ();

   bomb_scheduler #(
      .NUM_SLOTS   (NS),
      .FUSE_TICKS  (FT),
      .BLAST_TICKS (BT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: each slot is a single remaining-lifetime count (FUSE while life > BT,
   // BLAST while 1..BT, free at 0) plus an event flag.
   int life [NS];
   int mtx  [NS];
   int mty  [NS];
   bit mp   [NS];
   bit e_ack, e_nack, e_bv, e_bomb, e_blast;
   int e_btx, e_bty, e_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int  k, j, cnt, qx, qy, rtx, rty;
      bit  ok, hb, hbl, inr;
      if (rst) begin
         for (int i = 0; i < NS; i++) begin
            life[i] = 0; mtx[i] = 0; mty[i] = 0; mp[i] = 0;
         end
         e_ack = 0; e_nack = 0; e_bv = 0; e_bomb = 0; e_blast = 0;
         e_btx = 0; e_bty = 0; e_cnt = 0;
         return;
      end
      cnt = 0;
      for (int i = 0; i < NS; i++) if (life[i] > 0) cnt++;
      e_cnt = cnt;
      // tile query
      qx = int'(bus.px) / 16;
      qy = int'(bus.py) / 16;
      inr = (int'(bus.px) < 640) && (int'(bus.py) < 480);
      hb = 0; hbl = 0;
      for (int i = 0; i < NS; i++)
         if (life[i] > 0 && mtx[i] == qx && mty[i] == qy) begin
            if (life[i] <= BT) hbl = 1; else hb = 1;
         end
      e_blast = inr && hbl;
      e_bomb  = inr && hb && !hbl;
      // placement, decided on the state before this edge
      k = -1; e_ack = 0; e_nack = 0;
      if (bus.place_req) begin
         rtx = int'(bus.place_tx);
         rty = int'(bus.place_ty);
         ok = (rtx < 40) && (rty < 30);
         for (int i = 0; i < NS; i++)
            if (life[i] > 0 && mtx[i] == rtx && mty[i] == rty) ok = 0;
         if (ok)
            for (int i = NS - 1; i >= 0; i--)
               if (life[i] == 0 && !mp[i]) k = i;
         if (k < 0) ok = 0;
         e_ack = ok; e_nack = !ok;
         if (!ok) k = -1;
      end
      // one event per cycle, lowest slot first
      j = -1;
      for (int i = NS - 1; i >= 0; i--) if (mp[i]) j = i;
      e_bv = (j >= 0);
      if (j >= 0) begin
         e_btx = mtx[j]; e_bty = mty[j]; mp[j] = 0;
      end
      if (bus.tick)
         for (int i = 0; i < NS; i++)
            if (life[i] > 0) begin
               life[i]--;
               if (life[i] == BT) mp[i] = 1;
            end
      if (k >= 0) begin
         life[k] = FT + BT; mtx[k] = int'(bus.place_tx); mty[k] = int'(bus.place_ty);
      end
   endtask

   task automatic check_all();
      chk("ack",       32'(bus.place_ack),    32'(e_ack));
      chk("nack",      32'(bus.place_nack),   32'(e_nack));
      chk("boom_valid",32'(bus.boom_valid),   32'(e_bv));
      chk("pix_bomb",  32'(bus.pix_bomb),     32'(e_bomb));
      chk("pix_blast", 32'(bus.pix_blast),    32'(e_blast));
      chk("count",     32'(bus.active_count), 32'(e_cnt));
      if (e_bv) begin
         chk("boom_tx", 32'(bus.boom_tx), 32'(e_btx));
         chk("boom_ty", 32'(bus.boom_ty), 32'(e_bty));
      end
   endtask

   task automatic cyc(input bit req, input int tx, input int ty, input bit tk);
      bus.place_req = req;
      bus.place_tx  = 6'(tx);
      bus.place_ty  = 5'(ty);
      bus.tick      = tk;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.px = 10'd700;
      bus.py = 10'd0;
      idle(2);
      rst = 1'b0;
      chk("rst_ack",  32'(bus.place_ack),    32'd0);
      chk("rst_boom", 32'(bus.boom_valid),   32'd0);
      chk("rst_btx",  32'(bus.boom_tx),      32'd0);
      chk("rst_bty",  32'(bus.boom_ty),      32'd0);
      chk("rst_cnt",  32'(bus.active_count), 32'd0);

      // 1: single bomb life cycle with tile query at the tile edges
      cyc(1, 5, 7, 0);   chk("t1_ack", 32'(bus.place_ack), 32'd1);
      idle(1);           chk("t1_cnt", 32'(bus.active_count), 32'd1);
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      bus.px = 10'd80; bus.py = 10'd112;
      idle(1);
      chk("t1_boom", 32'(bus.boom_valid), 32'd1);
      chk("t1_btx",  32'(bus.boom_tx),    32'd5);
      chk("t1_bty",  32'(bus.boom_ty),    32'd7);
      chk("t1_blast_lo", 32'(bus.pix_blast), 32'd1);
      bus.px = 10'd95; bus.py = 10'd127;
      idle(1);           chk("t1_blast_hi", 32'(bus.pix_blast), 32'd1);
      bus.px = 10'd96;
      idle(1);           chk("t1_blast_out", 32'(bus.pix_blast), 32'd0);
      cyc(0, 0, 0, 1);
      idle(2);           chk("t1_cnt0", 32'(bus.active_count), 32'd0);

      // 2: duplicate and range checks
      cyc(1, 5, 7, 0);   chk("t2_ack", 32'(bus.place_ack), 32'd1);
      cyc(1, 5, 7, 0);   chk("t2_dup", 32'(bus.place_nack), 32'd1);
      cyc(1, 39, 29, 0); chk("t2_corner", 32'(bus.place_ack), 32'd1);
      cyc(1, 40, 0, 0);  chk("t2_txrange", 32'(bus.place_nack), 32'd1);
      cyc(1, 0, 30, 0);  chk("t2_tyrange", 32'(bus.place_nack), 32'd1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      idle(4);

      // 3: full pool, tick-freed slot reusable only the next cycle
      for (int i = 0; i < 4; i++) cyc(1, i, 1, 0);
      cyc(1, 10, 10, 0); chk("t3_full", 32'(bus.place_nack), 32'd1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      idle(6);
      cyc(1, 20, 20, 1); chk("t3_same", 32'(bus.place_nack), 32'd1);
      cyc(1, 20, 20, 0); chk("t3_next", 32'(bus.place_ack), 32'd1);
      bus.px = 10'd323; bus.py = 10'd325;
      cyc(1, 21, 21, 0); chk("t3_pixbomb", 32'(bus.pix_bomb), 32'd1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      idle(1);           chk("t3_slot0", 32'(bus.boom_tx), 32'd20);
      idle(2); cyc(0, 0, 0, 1); idle(3);

      // 4: simultaneous expiries drain in slot order
      rst = 1'b1; idle(1); rst = 1'b0;
      cyc(1, 2, 3, 0); cyc(1, 4, 5, 0); cyc(1, 6, 7, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      idle(1); chk("t4_b0", 32'({bus.boom_valid, bus.boom_tx}), 32'({1'b1, 6'd2}));
      idle(1); chk("t4_b1", 32'({bus.boom_valid, bus.boom_tx}), 32'({1'b1, 6'd4}));
      idle(1); chk("t4_b2", 32'({bus.boom_valid, bus.boom_ty}), 32'({1'b1, 5'd7}));
      idle(1); chk("t4_end", 32'(bus.boom_valid), 32'd0);
      cyc(0, 0, 0, 1); idle(2);

      // 5: place with tick in the same cycle keeps the full fuse
      rst = 1'b1; idle(1); rst = 1'b0;
      cyc(1, 8, 8, 1);   chk("t5_ack", 32'(bus.place_ack), 32'd1);
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      idle(2);           chk("t5_early", 32'(bus.boom_valid), 32'd0);
      cyc(0, 0, 0, 1);
      idle(1);           chk("t5_boom", 32'(bus.boom_valid), 32'd1);

      // 6: reset with live fuse and queued events
      rst = 1'b1; idle(1); rst = 1'b0;
      cyc(1, 1, 1, 0); cyc(1, 2, 2, 0); cyc(0, 0, 0, 1);
      cyc(1, 3, 3, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      rst = 1'b1; idle(1); rst = 1'b0;
      chk("t6_boom", 32'(bus.boom_valid), 32'd0);
      chk("t6_cnt",  32'(bus.active_count), 32'd0);
      chk("t6_ack",  32'({bus.place_ack, bus.place_nack, bus.pix_bomb, bus.pix_blast}), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 1);
         chk("t6_quiet", 32'(bus.boom_valid), 32'd0);
      end

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         int tx, ty;
         rst = ($urandom_range(0, 99) == 0);
         tx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(38, 41)) : int'($urandom_range(0, 5));
         ty = ($urandom_range(0, 9) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            bus.px = 10'($urandom_range(0, 95));
            bus.py = 10'($urandom_range(0, 63));
         end else begin
            bus.px = 10'($urandom_range(0, 1023));
            bus.py = 10'($urandom_range(0, 1023));
         end
         cyc(bit'($urandom_range(0, 9) < 3), tx, ty, bit'($urandom_range(0, 3) == 0));
      end
      rst = 1'b0;
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
